// File: rtl/ether_payload_serializer.sv
// Frame buffer and dibit serializer feeding the RMII Ethernet transmitter.
// Buffers a full payload, triggers the transmitter, then streams header + payload MSB-first.
module ether_payload_serializer #(
  parameter int unsigned PAYLOAD_BYTES = 64
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        in_valid_in,
  input  logic [7:0]  in_data_in,
  output logic        in_ready_out,
  input  logic        tx_ready_in,
  input  logic        tx_data_ready_in,
  output logic        tx_trigger_out,
  output logic [1:0]  tx_data_out,
  output logic        tx_last_dibit_out,
  output logic [15:0] seq_out,
  output logic        busy_out
);

  localparam int unsigned SEQ_W        = 16;
  localparam int unsigned CNT_W        = $clog2(PAYLOAD_BYTES + 1);
  localparam int unsigned ADDR_W       = $clog2(PAYLOAD_BYTES);
  localparam int unsigned TOTAL_DIBITS = 4 * (PAYLOAD_BYTES + 2);
  localparam int unsigned DCNT_W       = $clog2(TOTAL_DIBITS);

  typedef enum logic [2:0] {
    S_FILL,
    S_ARM,
    S_WAIT_DATA,
    S_SEND,
    S_DRAIN
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    count_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [7:0]          rd_q;
  logic [7:0]          pre_q;
  logic [7:0]          sh_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic [SEQ_W-1:0]    seq_q;
  logic                seen_low_q;
  logic                in_ready_q;
  logic                busy_q;
  logic                last_q;
  logic                accept_c;
  logic                consume_c;
  logic [7:0]          buf_mem [PAYLOAD_BYTES];

  assign accept_c  = (state_q == S_FILL) && in_valid_in && in_ready_q;
  assign consume_c = ((state_q == S_WAIT_DATA) || (state_q == S_SEND)) && tx_data_ready_in;

  // Frame buffer: write port from upstream, synchronous read port for the prefetcher.
  always_ff @(posedge clk_in) begin
    if (accept_c) begin
      buf_mem[count_q[ADDR_W-1:0]] <= in_data_in;
    end
    rd_q <= buf_mem[rd_ptr_q];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= S_FILL;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      pre_q      <= '0;
      sh_q       <= '0;
      dcnt_q     <= '0;
      seq_q      <= '0;
      seen_low_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          in_ready_q <= 1'b1;
          if (accept_c) begin
            count_q <= count_q + CNT_W'(1);
            if (count_q == CNT_W'(PAYLOAD_BYTES - 1)) begin
              state_q    <= S_ARM;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end

        S_ARM: begin
          // Dibit 0 must already be on the wire when data_ready first rises.
          if (tx_ready_in) begin
            state_q <= S_WAIT_DATA;
            sh_q    <= seq_q[15:8];
            pre_q   <= seq_q[7:0];
            dcnt_q  <= '0;
            last_q  <= 1'b0;
          end
        end

        S_WAIT_DATA, S_SEND: begin
          if (consume_c) begin
            if (last_q) begin
              state_q    <= S_DRAIN;
              sh_q       <= '0;
              last_q     <= 1'b0;
              seen_low_q <= 1'b0;
            end else begin
              state_q <= S_SEND;
              dcnt_q  <= dcnt_q + DCNT_W'(1);
              last_q  <= (dcnt_q == DCNT_W'(TOTAL_DIBITS - 2));
              if (dcnt_q[1:0] == 2'd3) begin
                // Byte boundary: swap in the prefetched byte and fetch the one after it.
                sh_q  <= pre_q;
                pre_q <= rd_q;
                if (rd_ptr_q != ADDR_W'(PAYLOAD_BYTES - 1)) begin
                  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                end
              end else begin
                sh_q <= {sh_q[5:0], 2'b00};
              end
            end
          end
        end

        S_DRAIN: begin
          // Transmitter must drop ready and raise it again (CRC + IFG done).
          if (!tx_ready_in) begin
            seen_low_q <= 1'b1;
          end else if (seen_low_q) begin
            state_q    <= S_FILL;
            seq_q      <= seq_q + SEQ_W'(1);
            count_q    <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            seen_low_q <= 1'b0;
          end
        end

        default: begin
          state_q <= S_FILL;
        end
      endcase
    end
  end

  assign in_ready_out      = in_ready_q;
  assign tx_trigger_out    = (state_q == S_ARM) && tx_ready_in;
  assign tx_data_out       = sh_q[7:6];
  assign tx_last_dibit_out = last_q;
  assign seq_out           = seq_q;
  assign busy_out          = busy_q;

endmodule
